// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared state type, word width and slave address constants for the I2C config arbiter
package i2c_arb_pkg;
  localparam int I2C_WORD_W = 24;
  localparam logic [7:0] SLV_CODEC = 8'h34;
  localparam logic [7:0] SLV_VIDEO = 8'h40;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_LO, WAIT_HI, GAP, RETIRE} state_t;
endpackage

// File: rtl/i2c_cfg_arbiter_if.sv
// i2c_cfg_arbiter_if: requester handshake and shared-controller port of the arbiter
// master = arbiter side; slave = config sequencers plus the byte-transfer controller
// i_req/i_data: per-requester level request and 24-bit word; o_grant/o_done/o_err: per-requester status
// o_I2C_DATA/o_I2C_GO: to controller; i_I2C_END/i_I2C_ACK: from controller (divided clock domain)
interface i2c_cfg_arbiter_if
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0] i_req, o_grant, o_done, o_err;
  logic [I2C_WORD_W*N_REQ-1:0] i_data;
  logic [I2C_WORD_W-1:0] o_I2C_DATA;
  logic o_I2C_GO, i_I2C_END, i_I2C_ACK;
  modport master (
    input  i_req, i_data, i_I2C_END, i_I2C_ACK,
    output o_grant, o_done, o_err, o_I2C_DATA, o_I2C_GO
  );
  modport slave (
    output i_req, i_data, i_I2C_END, i_I2C_ACK,
    input  o_grant, o_done, o_err, o_I2C_DATA, o_I2C_GO
  );
endinterface

// File: rtl/i2c_rr_picker.sv
// i2c_rr_picker: combinational round-robin encoder, first set request at or after i_ptr
// i_req: requests; i_ptr: priority start index; o_grant: one-hot winner (0 if none); o_idx: winner index
module i2c_rr_picker #(
  parameter int N_REQ = 3,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [PW-1:0]    o_idx
);
  logic [N_REQ-1:0] w_rot;
  logic [PW:0]      w_sum;
  always_comb begin
    w_rot = N_REQ'({i_req, i_req} >> i_ptr);
    w_sum = '0;
    // descending scan so the smallest offset from i_ptr wins
    for (int i = N_REQ - 1; i >= 0; i--)
      if (w_rot[i]) w_sum = {1'b0, i_ptr} + (PW + 1)'(i);
    o_idx   = (w_sum >= (PW + 1)'(N_REQ)) ? PW'(w_sum - (PW + 1)'(N_REQ)) : PW'(w_sum);
    o_grant = |i_req ? N_REQ'(1) << o_idx : '0;
  end
endmodule

// File: rtl/i2c_cfg_arbiter.sv
// i2c_cfg_arbiter: round-robin sharing of one I2C byte-transfer controller among N_REQ config masters
// iCLK: clock; iRST_N: synchronous active-low reset
// bus: i2c_cfg_arbiter_if.master (requests, data, grant/done/err, controller GO/DATA/END/ACK)
// o_busy: high whenever the FSM is not IDLE
// o_timeout: sticky watchdog flag, present only when I2C_ARB_TIMEOUT_EN is defined
module i2c_cfg_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int MAX_RETRY = 3,
  parameter int GAP_CYC   = 64
`ifdef I2C_ARB_TIMEOUT_EN
  ,
  parameter int TMO_CYC   = 1 << 20
`endif
) (
  input  logic iCLK,
  input  logic iRST_N,
  i2c_cfg_arbiter_if.master bus,
  output logic o_busy
`ifdef I2C_ARB_TIMEOUT_EN
  ,
  output logic o_timeout
`endif
);
  localparam int PW = $clog2(N_REQ);
  localparam int GW = $clog2(GAP_CYC + 1);
  state_t r_state, w_next;
  logic [1:0] r_end_s, r_ack_s;
  logic [PW-1:0] r_ptr, r_idx, w_idx;
  logic [N_REQ-1:0] w_pick, r_grant, r_done, r_err;
  logic [I2C_WORD_W-1:0] r_data, w_word;
  logic [3:0] r_retry;
  logic [GW-1:0] r_gap;
  logic r_go, w_end, w_ack, w_wait, w_tmo, w_fail;
  i2c_rr_picker #(.N_REQ(N_REQ)) u_pick (
    .i_req  (bus.i_req),
    .i_ptr  (r_ptr),
    .o_grant(w_pick),
    .o_idx  (w_idx)
  );
  assign w_end  = r_end_s[1];
  assign w_ack  = r_ack_s[1];
  assign w_wait = r_state == WAIT_LO || r_state == WAIT_HI;
  // RETIRE is only entered from a wait state: failure is a timeout or a NACK at END
  assign w_fail = w_tmo || w_ack;
  always_comb begin
    w_word = '0;
    for (int k = 0; k < N_REQ; k++)
      if (w_pick[k]) w_word = bus.i_data[k*I2C_WORD_W +: I2C_WORD_W];
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = |bus.i_req ? LAUNCH : IDLE;
      LAUNCH:  w_next = WAIT_LO;
      // END must be seen low first so a stale END=1 from the last transfer is ignored
      WAIT_LO: w_next = w_tmo ? RETIRE : !w_end ? WAIT_HI : WAIT_LO;
      WAIT_HI: w_next = w_tmo ? RETIRE : !w_end ? WAIT_HI :
                        (w_ack && r_retry < 4'(MAX_RETRY)) ? GAP : RETIRE;
      GAP:     w_next = (r_gap == GW'(GAP_CYC - 1)) ? LAUNCH : GAP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state <= IDLE;
      r_end_s <= '0;
      r_ack_s <= '0;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_retry <= '0;
      r_gap   <= '0;
      r_data  <= '0;
      r_go    <= 1'b0;
      r_grant <= '0;
      r_done  <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_next;
      r_end_s <= {r_end_s[0], bus.i_I2C_END};
      r_ack_s <= {r_ack_s[0], bus.i_I2C_ACK};
      r_go    <= w_next == WAIT_LO || w_next == WAIT_HI;
      r_gap   <= (r_state == GAP) ? r_gap + GW'(1) : '0;
      r_done  <= '0;
      r_err   <= '0;
      if (r_state == IDLE && |bus.i_req) begin
        r_idx   <= w_idx;
        r_grant <= w_pick;
        r_data  <= w_word;
      end
      if (r_state == WAIT_HI && w_next == GAP) r_retry <= r_retry + 4'd1;
      if (w_next == RETIRE) begin
        r_grant <= '0;
        r_done  <= w_fail ? '0 : N_REQ'(1) << r_idx;
        r_err   <= w_fail ? N_REQ'(1) << r_idx : '0;
      end
      if (r_state == RETIRE) begin
        r_ptr   <= (r_idx == PW'(N_REQ - 1)) ? '0 : r_idx + PW'(1);
        r_retry <= '0;
      end
    end
  end
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] r_tmo;
  logic r_timeout;
  // counter is held at zero outside the wait states, so every LAUNCH restarts it
  assign w_tmo     = w_wait && r_tmo == TW'(TMO_CYC - 1);
  assign o_timeout = r_timeout;
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_tmo     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tmo     <= w_wait ? r_tmo + TW'(1) : '0;
      r_timeout <= r_timeout | w_tmo;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif
  assign o_busy         = r_state != IDLE;
  assign bus.o_grant    = r_grant;
  assign bus.o_done     = r_done;
  assign bus.o_err      = r_err;
  assign bus.o_I2C_DATA = r_data;
  assign bus.o_I2C_GO   = r_go;
endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
// tb_i2c_cfg_arbiter: directed self-checking bench with a simple controller model driving END/ACK
module tb_i2c_cfg_arbiter;
  import i2c_arb_pkg::*;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
`ifdef I2C_ARB_TIMEOUT_EN
  logic tmo;
`endif
  int checks = 0, errors = 0;
  int go_cnt, lo_run, min_gap, overlap, nacks, ctl_t, n;
  int done_cnt[N], err_cnt[N];
  int order[$];
  logic [23:0] datq[$];
  logic go_q, ctl_auto, rel_en;
  logic [N-1:0] grant_q;

  always #5 clk = ~clk;

  i2c_cfg_arbiter_if #(.N_REQ(N)) bus ();

  i2c_cfg_arbiter #(
    .N_REQ(N), .MAX_RETRY(3), .GAP_CYC(64)
`ifdef I2C_ARB_TIMEOUT_EN
    , .TMO_CYC(1000)
`endif
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .bus(bus), .o_busy(busy)
`ifdef I2C_ARB_TIMEOUT_EN
    , .o_timeout(tmo)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    go_cnt = 0; min_gap = 1000000; overlap = 0;
    order.delete(); datq.delete();
    for (int k = 0; k < N; k++) begin done_cnt[k] = 0; err_cnt[k] = 0; end
  endtask

  // one negedge: controller model, requester release, monitors
  task automatic step();
    @(negedge clk);
    if (bus.o_I2C_GO && !go_q) begin
      go_cnt++;
      if (go_cnt > 1 && lo_run < min_gap) min_gap = lo_run;
      datq.push_back(bus.o_I2C_DATA);
      if (ctl_auto) ctl_t = 0;
    end else if (ctl_t >= 0) ctl_t++;
    if (ctl_auto && ctl_t == 3) bus.i_I2C_END = 1'b0;
    if (ctl_auto && ctl_t == 13) begin
      bus.i_I2C_ACK = nacks > 0;
      if (nacks > 0) nacks--;
      bus.i_I2C_END = 1'b1;
      ctl_t = -1;
    end
    lo_run = bus.o_I2C_GO ? 0 : lo_run + 1;
    if (|bus.o_grant && !(|grant_q))
      for (int k = 0; k < N; k++) if (bus.o_grant[k]) order.push_back(k);
    if (!$onehot0(bus.o_grant)) overlap++;
    for (int k = 0; k < N; k++) begin
      done_cnt[k] += int'(bus.o_done[k]);
      err_cnt[k]  += int'(bus.o_err[k]);
    end
    if (rel_en) bus.i_req = bus.i_req & ~(bus.o_done | bus.o_err);
    go_q = bus.o_I2C_GO;
    grant_q = bus.o_grant;
  endtask

  task automatic wait_idle(input int lim, input string tag);
    int c = 0;
    while ((busy || |bus.i_req) && c < lim) begin step(); c++; end
    chk(tag, c < lim, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req = '0; bus.i_data = '0; bus.i_I2C_END = 1'b1; bus.i_I2C_ACK = 1'b0;
    go_q = 1'b0; grant_q = '0; ctl_auto = 1'b1; rel_en = 1'b1;
    nacks = 0; ctl_t = -1; lo_run = 0;
    clr();
    repeat (3) step();
    chk("rst_grant", bus.o_grant, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_go", bus.o_I2C_GO, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", bus.o_I2C_DATA, 0);
    rst_n = 1'b1;
    step();
    // single request, late i_data change must not matter
    bus.i_data[23:0] = {SLV_CODEC, 16'h001A};
    bus.i_req = 3'b001;
    step();
    chk("t1_grant", bus.o_grant, 3'b001);
    chk("t1_go_early", bus.o_I2C_GO, 0);
    bus.i_data[23:0] = 24'hFFFFFF;
    step();
    chk("t1_go", bus.o_I2C_GO, 1);
    chk("t1_data", bus.o_I2C_DATA, 24'h34001A);
    wait_idle(200, "t1_idle");
    chk("t1_done", done_cnt[0], 1);
    chk("t1_err", err_cnt[0], 0);
    chk("t1_grant_off", bus.o_grant, 0);
    // all three requesting from a fresh pointer
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    clr();
    bus.i_data = {SLV_CODEC, 16'h0033, SLV_VIDEO, 16'h0022, SLV_CODEC, 16'h0011};
    rel_en = 1'b0;
    bus.i_req = 3'b111;
    n = 0;
    while (order.size() < 4 && n < 400) begin step(); n++; end
    chk("t2_four_grants", order.size() >= 4, 1);
    bus.i_req = '0;
    rel_en = 1'b1;
    wait_idle(200, "t2_idle");
    chk("t2_ord0", order[0], 0);
    chk("t2_ord1", order[1], 1);
    chk("t2_ord2", order[2], 2);
    chk("t2_ord3", order[3], 0);
    chk("t2_done0", done_cnt[0], 2);
    chk("t2_done1", done_cnt[1], 1);
    chk("t2_done2", done_cnt[2], 1);
    chk("t2_overlap", overlap, 0);
    chk("t2_dat1", datq[1], 24'h400022);
    chk("t2_dat3", datq[3], 24'h340011);
    // NACK forever: 1 + 3 retries, then err
    clr();
    nacks = 4;
    bus.i_req = 3'b010;
    wait_idle(1000, "t3_idle");
    chk("t3_launches", go_cnt, 4);
    chk("t3_gap_ge64", min_gap >= 64, 1);
    chk("t3_err", err_cnt[1], 1);
    chk("t3_done", done_cnt[1], 0);
    // two NACKs then ACK
    clr();
    nacks = 2;
    bus.i_req = 3'b100;
    wait_idle(1000, "t4_idle");
    chk("t4_launches", go_cnt, 3);
    chk("t4_done", done_cnt[2], 1);
    chk("t4_err", err_cnt[2], 0);
    // three NACKs only succeeds if the retry count was cleared
    clr();
    nacks = 3;
    bus.i_req = 3'b001;
    wait_idle(1000, "t4b_idle");
    chk("t4b_launches", go_cnt, 4);
    chk("t4b_done", done_cnt[0], 1);
    chk("t4b_err", err_cnt[0], 0);
    // stale END=1 at launch
    clr();
    ctl_auto = 1'b0;
    ctl_t = -1;
    bus.i_req = 3'b001;
    repeat (40) step();
    chk("t5_go_hold", bus.o_I2C_GO, 1);
    chk("t5_busy", busy, 1);
    chk("t5_no_done", done_cnt[0], 0);
    bus.i_I2C_END = 1'b0;
    repeat (10) step();
    chk("t5_go_lo", bus.o_I2C_GO, 1);
    chk("t5_no_done2", done_cnt[0], 0);
    bus.i_I2C_ACK = 1'b0;
    bus.i_I2C_END = 1'b1;
    wait_idle(100, "t5_idle");
    chk("t5_done", done_cnt[0], 1);
    // reset while waiting for END high
    clr();
    bus.i_req = 3'b010;
    repeat (8) step();
    bus.i_I2C_END = 1'b0;
    repeat (8) step();
    chk("t5_pre_rst_go", bus.o_I2C_GO, 1);
    rst_n = 1'b0;
    bus.i_req = '0;
    step();
    chk("t5_rst_go", bus.o_I2C_GO, 0);
    chk("t5_rst_grant", bus.o_grant, 0);
    chk("t5_rst_busy", busy, 0);
    bus.i_I2C_END = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("t5_rst_pulses", done_cnt[1] + err_cnt[1], 0);
    ctl_auto = 1'b1;
    ctl_t = -1;
`ifdef I2C_ARB_TIMEOUT_EN
    clr();
    chk("t6_tmo_init", tmo, 0);
    ctl_auto = 1'b0;
    bus.i_I2C_END = 1'b0;
    bus.i_req = 3'b100;
    n = 0;
    while (!bus.o_I2C_GO && n < 10) begin step(); n++; end
    chk("t6_go", bus.o_I2C_GO, 1);
    n = 0;
    while (!bus.o_err[2] && n < 1200) begin step(); n++; end
    chk("t6_tmo_cycles", n >= 998 && n <= 1002, 1);
    chk("t6_tmo_flag", tmo, 1);
    bus.i_I2C_END = 1'b1;
    ctl_auto = 1'b1;
    ctl_t = -1;
    repeat (3) step();
    clr();
    bus.i_req = 3'b001;
    wait_idle(200, "t6_idle");
    chk("t6_next_done", done_cnt[0], 1);
    chk("t6_tmo_sticky", tmo, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
